// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/execute sequencer owning the PC, with imem and dmem handshakes.
module instr_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 10,
  parameter int RESET_PC    = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   commit,
  output logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   regfile_clear,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired_count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]             op;
  logic                   is_mem, is_halt, done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_WIDTH'(RESET_PC);
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = imem_valid ? EXEC : FETCH;
      EXEC:    state_d = is_halt ? HALT : is_mem ? MEM : run ? FETCH : IDLE;
      MEM:     state_d = !dmem_ready ? MEM : run ? FETCH : IDLE;
      default: state_d = HALT;
    endcase
    // NOPs complete (advance pc) without committing
    pc_d    = !done ? pc_q : (state_q == EXEC && op == 4'h9) ? PC_WIDTH'(instr_q[5:0]) : pc_q + PC_WIDTH'(1);
    instr_d = (state_q == FETCH && imem_valid) ? imem_data : instr_q;
    cnt_d   = (commit && !(&cnt_q)) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
  end
  always_comb begin
    op            = instr_q[INSTR_WIDTH-1 -: 4];
    is_mem        = op == 4'hB || op == 4'hC;
    is_halt       = op == 4'hF;
    imem_req      = state_q == FETCH;
    dmem_req      = state_q == MEM;
    halted        = state_q == HALT;
    commit        = (state_q == EXEC) ? op <= 4'hA : (state_q == MEM && dmem_ready);
    regfile_clear = state_q == EXEC && op == 4'h7;
    done          = (state_q == EXEC) ? !is_mem && !is_halt : (state_q == MEM && dmem_ready);
    imem_addr     = pc_q;
    pc            = pc_q;
    instr         = instr_q;
    retired_count = cnt_q;
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: random + directed stimulus checked every cycle against a behavioural model.
module tb_instr_sequencer;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 1, run = 0, imem_valid = 0, dmem_ready = 0;
  logic [9:0] imem_data = '0;
  logic imem_req, commit, dmem_req, regfile_clear, halted;
  logic [7:0] imem_addr, pc;
  logic [9:0] instr;
  logic [CW-1:0] retired_count;

  instr_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .instr(instr), .commit(commit),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .regfile_clear(regfile_clear),
    .pc(pc), .halted(halted), .retired_count(retired_count));

  always #5 clk = ~clk;

  logic [9:0] mem [256];
  bit rnd = 0;
  int valid_delay = 0, ready_delay = 0, fetch_run = 0, req_run = 0;
  int m_tot = 0, m_pass = 0, d_tot = 0, d_pass = 0;
  int n_commit = 0, n_clear = 0, cur_len = 0;
  int lens[$];

  // Model: phase 0 idle, 1 waiting for word, 2 executing, 3 waiting on dmem, 4 stopped
  bit m_live = 0;
  int m_ph, m_pc, m_instr, m_cnt, m_op;
  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_ph = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
    end else if (m_live) begin
      m_op = m_instr >> 6;
      if (m_ph == 0) m_ph = run ? 1 : 0;
      else if (m_ph == 1 && imem_valid) begin m_instr = imem_data; m_ph = 2; end
      else if (m_ph == 2) begin
        if (m_op == 15) m_ph = 4;
        else if (m_op == 11 || m_op == 12) m_ph = 3;
        else begin
          if (m_op <= 10) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
          m_pc = (m_op == 9) ? (m_instr % 64) : (m_pc + 1) % 256;
          m_ph = run ? 1 : 0;
        end
      end else if (m_ph == 3 && dmem_ready) begin
        m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
        m_pc = (m_pc + 1) % 256;
        m_ph = run ? 1 : 0;
      end
    end
  end

  logic [36:0] exp_v, act_v;
  always @(negedge clk) begin
    if (m_live) begin
      exp_v = {m_ph == 1, m_ph == 3,
               (m_ph == 2 && (m_instr >> 6) <= 10) || (m_ph == 3 && dmem_ready),
               m_ph == 2 && (m_instr >> 6) == 7, m_ph == 4,
               8'(m_pc), 8'(m_pc), 10'(m_instr), CW'(m_cnt)};
      act_v = {imem_req, dmem_req, commit, regfile_clear, halted, imem_addr, pc, instr, retired_count};
      m_tot++;
      if (act_v === exp_v) m_pass++;
      else $display("FAIL model_cycle t=%0t: got req/dreq/com/clr/hlt/addr/pc/instr/cnt=%b%b%b%b%b/%h/%h/%h/%h expected %b%b%b%b%b/%h/%h/%h/%h",
        $time, act_v[36], act_v[35], act_v[34], act_v[33], act_v[32], act_v[31:24], act_v[23:16], act_v[15:6], act_v[5:0],
        exp_v[36], exp_v[35], exp_v[34], exp_v[33], exp_v[32], exp_v[31:24], exp_v[23:16], exp_v[15:6], exp_v[5:0]);
      if (commit) n_commit++;
      if (regfile_clear) n_clear++;
      if (dmem_req) cur_len++;
      else if (cur_len > 0) begin lens.push_back(cur_len); cur_len = 0; end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    d_tot++;
    if (act == exp) d_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    fetch_run = imem_req ? fetch_run + 1 : 0;
    req_run = dmem_req ? req_run + 1 : 0;
    imem_data = mem[imem_addr];
    if (rnd) begin
      imem_valid = $urandom_range(9) < 6;
      dmem_ready = $urandom_range(1) == 1;
    end else begin
      imem_valid = imem_req && fetch_run > valid_delay;
      dmem_ready = dmem_req && req_run > ready_delay;
    end
  endtask

  task automatic do_reset();
    run = 0; reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 10'h3C0;
  endtask

  task automatic wait_halt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin tick(); n++; end
    if (!halted) chk("halt_timeout", 0, 1);
  endtask

  task automatic wait_req(input bit lvl);
    int n = 0;
    while (dmem_req != lvl && n < 50) begin tick(); n++; end
    if (dmem_req != lvl) chk("dmem_req_timeout", int'(dmem_req), int'(lvl));
  endtask

  int n, c0, l0, bad;
  initial begin
    fill_halt();
    mem[0] = 10'h000; mem[1] = 10'h040; mem[2] = 10'h080;
    do_reset();
    @(negedge clk);
    chk("rst_pc", pc, 0); chk("rst_cnt", retired_count, 0); chk("rst_instr", instr, 0);
    chk("rst_imem_req", imem_req, 0); chk("rst_dmem_req", dmem_req, 0);
    chk("rst_commit", commit, 0); chk("rst_halted", halted, 0);
    c0 = n_commit; run = 1;
    wait_halt(100, n);
    chk("prog3_cycles", n, 9); chk("prog3_pc", pc, 3); chk("prog3_cnt", retired_count, 3);
    chk("prog3_commits", n_commit - c0, 3);
    bad = 0;
    repeat (20) begin tick(); @(negedge clk); if (imem_req || !halted) bad++; end
    chk("halt_hold", bad, 0);

    fill_halt(); mem[0] = 10'h247; mem[7] = 10'h25A;
    do_reset(); run = 1; wait_halt(100, n);
    chk("jmp_pc", pc, 8'h1A); chk("jmp_cnt", retired_count, 2);

    for (int i = 0; i < 256; i++) mem[i] = 10'h000;
    do_reset(); run = 1;
    repeat (511) tick();
    @(negedge clk); chk("wrap_pc255", pc, 255);
    tick(); tick();
    @(negedge clk); chk("wrap_pc0", pc, 0); chk("sat_cnt", retired_count, CMAX);

    fill_halt(); for (int i = 0; i < 4; i++) mem[i] = 10'h000; mem[4] = 10'h2C0;
    ready_delay = 3; l0 = lens.size(); c0 = n_commit;
    do_reset(); run = 1; wait_halt(100, n);
    chk("load_req_len", (lens.size() > l0) ? lens[l0] : -1, 4);
    chk("load_pc", pc, 5); chk("load_commits", n_commit - c0, 5);

    fill_halt(); mem[0] = 10'h300; ready_delay = 0; l0 = lens.size();
    do_reset(); run = 1; wait_halt(100, n);
    chk("store_req_len", (lens.size() > l0) ? lens[l0] : -1, 1);
    chk("store_cycles", n, 6); chk("store_pc", pc, 1);

    fill_halt(); mem[0] = 10'h1C0; mem[1] = 10'h340; c0 = n_clear;
    do_reset(); run = 1; wait_halt(100, n);
    chk("rst_clear_pulses", n_clear - c0, 1); chk("nop_pc", pc, 2); chk("nop_cnt", retired_count, 1);

    fill_halt(); mem[0] = 10'h2C0; ready_delay = 5;
    do_reset(); run = 1; wait_req(1); run = 0; wait_req(0);
    repeat (3) tick();
    @(negedge clk);
    chk("drop_imem_req", imem_req, 0); chk("drop_pc", pc, 1);
    chk("drop_cnt", retired_count, 1); chk("drop_halted", halted, 0);
    run = 1; wait_halt(100, n);
    chk("resume_pc", pc, 1);

    fill_halt(); mem[0] = 10'h000; mem[1] = 10'h2C0; ready_delay = 100;
    do_reset(); run = 1; wait_req(1); tick(); tick();
    reset = 1; tick();
    @(negedge clk);
    chk("mrst_dmem_req", dmem_req, 0); chk("mrst_pc", pc, 0);
    chk("mrst_cnt", retired_count, 0); chk("mrst_instr", instr, 0);
    reset = 0;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 10'($urandom_range(1023));
      if (mem[i][9:6] == 4'hF && $urandom_range(3) != 0) mem[i] = 10'($urandom_range(10'h37F));
    end
    rnd = 1;
    do_reset();
    repeat (5000) begin
      tick();
      run = $urandom_range(99) < 85;
      reset = $urandom_range(199) == 0;
    end
    reset = 0; tick(); @(negedge clk);
    $display("%0d/%0d checks passed", m_pass + d_pass, m_tot + d_tot);
    $finish;
  end
endmodule
